// File: rtl/ball_pkg.sv
// Shared types, key codes and helpers for the ball motion controller.
//   dir_t      : resolved ball direction (3 bits, driven on the dir port)
//   state_t    : frame sequencer states
//   key_to_dir : map a keyboard scan code to a direction (DIR_NONE if not W/A/S/D)
//   step_axis  : one-axis step with 11-bit arithmetic and clamping
package ball_pkg;

    localparam int unsigned POS_W  = 10;
    localparam int unsigned AXIS_W = 11;
    localparam int unsigned KEY_WIDTH = 8;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        DECODE = 2'd1,
        BOUND  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [KEY_WIDTH-1:0] KEY_W = 8'h1A;
    localparam logic [KEY_WIDTH-1:0] KEY_A = 8'h04;
    localparam logic [KEY_WIDTH-1:0] KEY_S = 8'h16;
    localparam logic [KEY_WIDTH-1:0] KEY_D = 8'h07;

    // Scan code to direction; anything other than W/A/S/D yields DIR_NONE.
    function automatic dir_t key_to_dir(input logic [KEY_WIDTH-1:0] key);
        dir_t d;
        case (key)
            KEY_W:   d = DIR_UP;
            KEY_S:   d = DIR_DOWN;
            KEY_A:   d = DIR_LEFT;
            KEY_D:   d = DIR_RIGHT;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

    // Signed 11-bit step so a decrement below zero clamps instead of wrapping.
    function automatic logic [POS_W-1:0] step_axis(
        input logic [POS_W-1:0]  pos,
        input logic              inc,
        input logic              dec,
        input logic [AXIS_W-1:0] step,
        input logic [AXIS_W-1:0] lo,
        input logic [AXIS_W-1:0] hi
    );
        logic signed [AXIS_W-1:0] v;
        v = $signed({1'b0, pos});
        if (inc) v = v + $signed(step);
        if (dec) v = v - $signed(step);
        if (v < $signed(lo))      v = $signed(lo);
        else if (v > $signed(hi)) v = $signed(hi);
        return POS_W'(v);
    endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Frame start detector: 2-flop synchronizer on the asynchronous vsync followed
// by a rising-edge detector.
//   Clk      : system clock
//   Reset    : synchronous, active-high
//   async_in : asynchronous level input (VGA vsync)
//   tick     : combinational one-cycle pulse on a synchronized rising edge
module frame_tick_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic tick
);

    logic s1, s2, s3;

    // s1/s2 synchronize, s3 holds the previous synchronized level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-sequenced ball motion controller. Each frame start runs
// DECODE (key arbitration) -> BOUND (wall bounce) -> COMMIT (one step).
//   Clk        : system clock
//   Reset      : synchronous, active-high
//   frame_vs   : VGA vsync (asynchronous), rising edge = frame start
//   keycode    : two key slots, slot0 = [7:0], slot1 = [15:8], 8'h00 = empty
//   BallX/BallY: ball centre position
//   BallS      : ball radius (constant SIZE)
//   dir        : current direction
//   frame_done : one-cycle pulse when BallX/BallY hold the new frame's value
module ball_motion_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned X_CENTER = 320,
    parameter int unsigned Y_CENTER = 240,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SIZE     = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_vs,
    input  logic [15:0]       keycode,
    output logic [POS_W-1:0]  BallX,
    output logic [POS_W-1:0]  BallY,
    output logic [POS_W-1:0]  BallS,
    output dir_t              dir,
    output logic              frame_done
);

    localparam logic [AXIS_W-1:0] SIZE_A  = AXIS_W'(SIZE);
    localparam logic [AXIS_W-1:0] STEP_A  = AXIS_W'(STEP);
    localparam logic [AXIS_W-1:0] X_LO    = AXIS_W'(X_MIN + SIZE);
    localparam logic [AXIS_W-1:0] X_HI    = AXIS_W'(X_MAX - SIZE);
    localparam logic [AXIS_W-1:0] Y_LO    = AXIS_W'(Y_MIN + SIZE);
    localparam logic [AXIS_W-1:0] Y_HI    = AXIS_W'(Y_MAX - SIZE);
    localparam logic [AXIS_W-1:0] X_MAX_A = AXIS_W'(X_MAX);
    localparam logic [AXIS_W-1:0] Y_MAX_A = AXIS_W'(Y_MAX);

    state_t            state, state_next;
    logic              tick;
    logic              pending, pending_next;
    logic [15:0]       prev_key, prev_key_next;
    dir_t              dir_next;
    logic [POS_W-1:0]  x_next, y_next;
    logic              frame_done_next;

    logic [KEY_WIDTH-1:0] slot0, slot1;
    dir_t                 slot0_dir, slot1_dir;
    logic                 slot0_new, slot1_new;
    logic [AXIS_W-1:0]    x_ext, y_ext;

    assign BallS = POS_W'(SIZE);

    frame_tick_detect u_tick (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (frame_vs),
        .tick     (tick)
    );

    // A slot counts only when it is a fresh W/A/S/D press not already seen last frame.
    assign slot0     = keycode[7:0];
    assign slot1     = keycode[15:8];
    assign slot0_dir = key_to_dir(slot0);
    assign slot1_dir = key_to_dir(slot1);
    assign slot0_new = (slot0 != '0) && (slot0_dir != DIR_NONE)
                    && (slot0 != prev_key[7:0]) && (slot0 != prev_key[15:8]);
    assign slot1_new = (slot1 != '0) && (slot1_dir != DIR_NONE)
                    && (slot1 != prev_key[7:0]) && (slot1 != prev_key[15:8]);

    assign x_ext = {1'b0, BallX};
    assign y_ext = {1'b0, BallY};

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= WAIT;
        else       state <= state_next;
    end

    // Next-state and datapath next values.
    always_comb begin
        state_next      = state;
        pending_next    = pending;
        prev_key_next   = prev_key;
        dir_next        = dir;
        x_next          = BallX;
        y_next          = BallY;
        frame_done_next = 1'b0;

        // A frame start while busy is queued once; extra ones are dropped.
        if (state != WAIT && tick) pending_next = 1'b1;

        case (state)
            WAIT: begin
                if (tick || pending) begin
                    state_next   = DECODE;
                    pending_next = 1'b0;
                end
            end
            DECODE: begin
                prev_key_next = keycode;
                if (slot0_new)      dir_next = slot0_dir;
                else if (slot1_new) dir_next = slot1_dir;
                state_next = BOUND;
            end
            BOUND: begin
                // Bounce only off the wall the ball is heading toward.
                case (dir)
                    DIR_DOWN:  if (y_ext + SIZE_A >= Y_MAX_A)                 dir_next = DIR_UP;
                    DIR_UP:    if (y_ext <= AXIS_W'(Y_MIN) + SIZE_A)          dir_next = DIR_DOWN;
                    DIR_RIGHT: if (x_ext + SIZE_A >= X_MAX_A)                 dir_next = DIR_LEFT;
                    DIR_LEFT:  if (x_ext <= AXIS_W'(X_MIN) + SIZE_A)          dir_next = DIR_RIGHT;
                    default: ;
                endcase
                state_next = COMMIT;
            end
            COMMIT: begin
                x_next = step_axis(BallX, dir == DIR_RIGHT, dir == DIR_LEFT, STEP_A, X_LO, X_HI);
                y_next = step_axis(BallY, dir == DIR_DOWN,  dir == DIR_UP,   STEP_A, Y_LO, Y_HI);
                frame_done_next = 1'b1;
                state_next      = WAIT;
            end
            default: state_next = WAIT;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending    <= 1'b0;
            prev_key   <= 16'h0000;
            dir        <= DIR_NONE;
            BallX      <= POS_W'(X_CENTER);
            BallY      <= POS_W'(Y_CENTER);
            frame_done <= 1'b0;
        end else begin
            pending    <= pending_next;
            prev_key   <= prev_key_next;
            dir        <= dir_next;
            BallX      <= x_next;
            BallY      <= y_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed testbench for ball_motion_ctrl with hand-computed expectations.
module tb_ball_motion_ctrl;

    localparam int D_NONE  = 0;
    localparam int D_UP    = 1;
    localparam int D_DOWN  = 2;
    localparam int D_LEFT  = 3;
    localparam int D_RIGHT = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_vs = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic [9:0]  BallX, BallY, BallS;
    logic [2:0]  dir;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    ball_motion_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_vs   (frame_vs),
        .keycode    (keycode),
        .BallX      (BallX),
        .BallY      (BallY),
        .BallS      (BallS),
        .dir        (dir),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset    = 1'b1;
        frame_vs = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    // One vsync pulse; edge 0 is the first posedge sampling frame_vs=1.
    task automatic do_frame(input string tag);
        int lat;
        lat = -1;
        @(negedge Clk);
        frame_vs = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            if (frame_done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 5);
        @(posedge Clk);
        #1;
        check({tag, "_done_low"}, int'(frame_done), 0);
        @(negedge Clk);
        frame_vs = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int pulses;
        int first_edge, second_edge;

        // Test 1: reset state and idle frames.
        apply_reset();
        check("rst_x", int'(BallX), 320);
        check("rst_y", int'(BallY), 240);
        check("rst_dir", int'(dir), D_NONE);
        check("rst_done", int'(frame_done), 0);
        check("rst_size", int'(BallS), 4);
        for (int f = 0; f < 3; f++) do_frame("idle");
        check("idle_x", int'(BallX), 320);
        check("idle_y", int'(BallY), 240);
        check("idle_dir", int'(dir), D_NONE);

        // Test 2: D press moves right; held key keeps direction.
        keycode = 16'h0007;
        do_frame("right1");
        check("right1_dir", int'(dir), D_RIGHT);
        check("right1_x", int'(BallX), 321);
        for (int f = 0; f < 9; f++) do_frame("right_hold");
        check("right10_x", int'(BallX), 330);
        check("right10_dir", int'(dir), D_RIGHT);

        // Test 3: A, then W in slot1 while A held, then A alone (already seen).
        keycode = 16'h0004;
        do_frame("left1");
        check("left1_dir", int'(dir), D_LEFT);
        check("left1_x", int'(BallX), 329);
        keycode = 16'h1A04;
        do_frame("up1");
        check("up1_dir", int'(dir), D_UP);
        check("up1_y", int'(BallY), 239);
        keycode = 16'h0004;
        do_frame("up_hold");
        check("up_hold_dir", int'(dir), D_UP);
        check("up_hold_y", int'(BallY), 238);
        check("up_hold_x", int'(BallX), 329);

        // Test 4: both slots new, slot0 wins.
        keycode = 16'h0000;
        apply_reset();
        keycode = 16'h0716;
        do_frame("prio");
        check("prio_dir", int'(dir), D_DOWN);
        check("prio_y", int'(BallY), 241);
        check("prio_x", int'(BallX), 320);

        // Test 5: run right to the clamp edge and bounce.
        keycode = 16'h0000;
        apply_reset();
        keycode = 16'h0007;
        for (int f = 0; f < 315; f++) do_frame("run");
        check("edge_x", int'(BallX), 635);
        check("edge_dir", int'(dir), D_RIGHT);
        do_frame("bounce");
        check("bounce_dir", int'(dir), D_LEFT);
        check("bounce_x", int'(BallX), 634);
        do_frame("after_bounce");
        check("after_bounce_x", int'(BallX), 633);
        check("after_bounce_dir", int'(dir), D_LEFT);

        // Test 6a: second frame start lands in BOUND and is queued.
        keycode = 16'h0000;
        apply_reset();
        keycode = 16'h0007;
        pulses = 0;
        first_edge = -1;
        second_edge = -1;
        @(negedge Clk);
        frame_vs = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge Clk);
            #1;
            if (frame_done) begin
                pulses++;
                if (first_edge < 0) first_edge = i;
                else if (second_edge < 0) second_edge = i;
            end
            @(negedge Clk);
            if (i == 0) frame_vs = 1'b0;
            else if (i == 1) frame_vs = 1'b1;
            else if (i == 6) frame_vs = 1'b0;
        end
        check("queue_pulses", pulses, 2);
        check("queue_edge1", first_edge, 5);
        check("queue_edge2", second_edge, 9);
        check("queue_x", int'(BallX), 322);
        check("queue_dir", int'(dir), D_RIGHT);

        // Test 6b: reset during BOUND discards the frame.
        repeat (3) @(negedge Clk);
        frame_vs = 1'b1;
        for (int i = 0; i < 4; i++) @(posedge Clk);
        @(negedge Clk);
        Reset    = 1'b1;
        frame_vs = 1'b0;
        @(posedge Clk);
        #1;
        check("midrst_x", int'(BallX), 320);
        check("midrst_y", int'(BallY), 240);
        check("midrst_dir", int'(dir), D_NONE);
        check("midrst_done", int'(frame_done), 0);
        @(negedge Clk);
        Reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (frame_done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_x_hold", int'(BallX), 320);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
